ll_step_sequencer: RTL and testbench

//  Multi-cycle controller for one lunar-lander physics step, using a single shared BCD add/sub unit.
//  On each physics tick it snapshots alt/vel/fuel/thrust and sequences the shared 4-digit bcdaddsub4.
//  The sequence is touchdown check/alt update, vel-gravity, vel+thrust, then fuel-thrust.
//  It then issues a one-cycle write-enable to the state memory.
//  It replaces the four parallel adders plus the separate control adder between memory and display.

---
 rtl/ll_pkg.sv | 32 +++
 rtl/ll_step_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ll_step_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_pkg.sv
// ---------------------------------------------------------------------------
// ll_pkg
// Shared types and constants for the lunar-lander step sequencer.
//   ll_step_e     : sequencer state encoding
//   BCD_ZERO      : 4-digit BCD zero
//   GRAVITY_DEF   : default BCD amount subtracted from velocity each step
//   CRASH_VEL_DEF : default 10's-complement crash threshold
//   bcd_is_nonpos : true for a 10's-complement value that is negative or zero
// ---------------------------------------------------------------------------
package ll_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        S_ALT    = 3'd1,
        S_VELG   = 3'd2,
        S_VELT   = 3'd3,
        S_FUEL   = 3'd4,
        S_COMMIT = 3'd5,
        LANDED   = 3'd6,
        CRASHED  = 3'd7
    } ll_step_e;

    localparam logic [15:0] BCD_ZERO      = 16'h0000;
    localparam logic [15:0] GRAVITY_DEF   = 16'h0005;
    localparam logic [15:0] CRASH_VEL_DEF = 16'h9970;

    // A leading digit of 8 or 9 marks a negative 10's-complement value.
    function automatic logic bcd_is_nonpos(input logic [15:0] val);
        return val[15] | (val == BCD_ZERO);
    endfunction

endpackage

// File: rtl/ll_step_sequencer.sv
// ---------------------------------------------------------------------------
// ll_step_sequencer
// Runs one lunar-lander physics step over several cycles on a single shared
// 4-digit BCD add/sub unit (instantiated by the parent and wired to alu_*).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick, run           : step request and step enable
//   alt, vel, fuel,     : current state (BCD; vel is 10's complement)
//   thrust
//   alu_a, alu_b, alu_op: operands/operation to the shared adder (0 = add)
//   alu_s               : combinational adder result
//   alt_n, vel_n, fuel_n: registered next state
//   wen                 : one-cycle commit strobe
//   busy                : a step is in flight
//   land, crash         : sticky touchdown outcome flags
//   overrun             : tick arrived while a step was in flight
// ---------------------------------------------------------------------------
module ll_step_sequencer
    import ll_pkg::*;
#(
    parameter logic [15:0] GRAVITY   = GRAVITY_DEF,
    parameter logic [15:0] CRASH_VEL = CRASH_VEL_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        run,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_op,
    input  logic [15:0] alu_s,
    output logic [15:0] alt_n,
    output logic [15:0] vel_n,
    output logic [15:0] fuel_n,
    output logic        wen,
    output logic        busy,
    output logic        land,
    output logic        crash,
    output logic        overrun
);

    ll_step_e    state_r;
    ll_step_e    state_nxt_s;

    logic [15:0] alt_snap_r;
    logic [15:0] vel_snap_r;
    logic [15:0] fuel_snap_r;
    logic [15:0] thrust_snap_r;
    logic [15:0] alt_c_r;
    logic [15:0] vtmp_r;
    logic [15:0] alt_n_r;
    logic [15:0] vel_n_r;
    logic [15:0] fuel_n_r;
    logic        wen_r;
    logic        land_r;
    logic        crash_r;

    logic [15:0] alu_a_s;
    logic [15:0] alu_b_s;
    logic        alu_op_s;
    logic        busy_s;
    logic        soft_land_s;

    // Zero velocity counts as a soft touchdown, as does a small descent rate.
    assign soft_land_s = (vel_snap_r >= CRASH_VEL) | (vel_snap_r == BCD_ZERO);

    // Next-state decode and operand mux for the shared adder.
    always_comb begin
        state_nxt_s = state_r;
        alu_a_s     = BCD_ZERO;
        alu_b_s     = BCD_ZERO;
        alu_op_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick && run) begin
                    state_nxt_s = S_ALT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            S_ALT: begin
                alu_a_s = alt_snap_r;
                alu_b_s = vel_snap_r;
                if (bcd_is_nonpos(alu_s)) begin
                    if (soft_land_s) begin
                        state_nxt_s = LANDED;
                    end else begin
                        state_nxt_s = CRASHED;
                    end
                end else begin
                    state_nxt_s = S_VELG;
                end
            end
            S_VELG: begin
                alu_a_s     = vel_snap_r;
                alu_b_s     = GRAVITY;
                alu_op_s    = 1'b1;
                state_nxt_s = S_VELT;
            end
            S_VELT: begin
                // An empty tank produces no thrust.
                alu_a_s     = vtmp_r;
                alu_b_s     = (fuel_snap_r == BCD_ZERO) ? BCD_ZERO : thrust_snap_r;
                state_nxt_s = S_FUEL;
            end
            S_FUEL: begin
                alu_a_s     = fuel_snap_r;
                alu_b_s     = thrust_snap_r;
                alu_op_s    = 1'b1;
                state_nxt_s = S_COMMIT;
            end
            S_COMMIT: begin
                state_nxt_s = IDLE;
            end
            LANDED: begin
                state_nxt_s = LANDED;
            end
            CRASHED: begin
                state_nxt_s = CRASHED;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Busy covers every in-flight state, including the commit cycle.
    always_comb begin
        case (state_r)
            S_ALT, S_VELG, S_VELT, S_FUEL, S_COMMIT: busy_s = 1'b1;
            default:                                 busy_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Snapshot, intermediate and result registers plus outcome flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alt_snap_r    <= BCD_ZERO;
            vel_snap_r    <= BCD_ZERO;
            fuel_snap_r   <= BCD_ZERO;
            thrust_snap_r <= BCD_ZERO;
            alt_c_r       <= BCD_ZERO;
            vtmp_r        <= BCD_ZERO;
            alt_n_r       <= BCD_ZERO;
            vel_n_r       <= BCD_ZERO;
            fuel_n_r      <= BCD_ZERO;
            wen_r         <= 1'b0;
            land_r        <= 1'b0;
            crash_r       <= 1'b0;
        end else begin
            wen_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick && run) begin
                        alt_snap_r    <= alt;
                        vel_snap_r    <= vel;
                        fuel_snap_r   <= fuel;
                        thrust_snap_r <= thrust;
                    end
                end
                S_ALT: begin
                    alt_c_r <= alu_s;
                    if (state_nxt_s == LANDED) begin
                        land_r <= 1'b1;
                    end
                    if (state_nxt_s == CRASHED) begin
                        crash_r <= 1'b1;
                    end
                end
                S_VELG: begin
                    vtmp_r <= alu_s;
                end
                S_VELT: begin
                    vel_n_r <= alu_s;
                end
                S_FUEL: begin
                    // Fuel never goes negative; an overdraw empties the tank.
                    fuel_n_r <= bcd_is_nonpos(alu_s) ? BCD_ZERO : alu_s;
                    alt_n_r  <= alt_c_r;
                    wen_r    <= 1'b1;
                end
                default: begin
                    wen_r <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a   = alu_a_s;
    assign alu_b   = alu_b_s;
    assign alu_op  = alu_op_s;
    assign alt_n   = alt_n_r;
    assign vel_n   = vel_n_r;
    assign fuel_n  = fuel_n_r;
    assign wen     = wen_r;
    assign busy    = busy_s;
    assign land    = land_r;
    assign crash   = crash_r;
    assign overrun = tick & busy_s;

endmodule

// File: tb/tb_ll_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ll_step_sequencer
// Self-checking bench: hand-computed vector table, hand-written corner
// sequences (overrun, commit-edge tick, terminal states, mid-step reset) and
// randomized steps against a decimal-arithmetic reference model. The shared
// BCD add/sub unit is modelled here with plain decimal arithmetic.
// ---------------------------------------------------------------------------
module tb_ll_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic [15:0] alt = 16'h0000;
    logic [15:0] vel = 16'h0000;
    logic [15:0] fuel = 16'h0000;
    logic [15:0] thrust = 16'h0000;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_op;
    logic [15:0] alu_s;
    logic [15:0] alt_n;
    logic [15:0] vel_n;
    logic [15:0] fuel_n;
    logic        wen;
    logic        busy;
    logic        land;
    logic        crash;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] v;
        logic [15:0] f;
        logic [15:0] t;
        int          outcome;   // 0 = normal step, 1 = landed, 2 = crashed
        logic [15:0] ea;
        logic [15:0] ev;
        logic [15:0] ef;
    } vec_t;

    ll_step_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .run     (run),
        .alt     (alt),
        .vel     (vel),
        .fuel    (fuel),
        .thrust  (thrust),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_s   (alu_s),
        .alt_n   (alt_n),
        .vel_n   (vel_n),
        .fuel_n  (fuel_n),
        .wen     (wen),
        .busy    (busy),
        .land    (land),
        .crash   (crash),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic int dec(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] bcd(input int x);
        logic [15:0] r;
        int          m;
        m        = ((x % 10000) + 10000) % 10000;
        r[15:12] = 4'(m / 1000);
        r[11:8]  = 4'((m / 100) % 10);
        r[7:4]   = 4'((m / 10) % 10);
        r[3:0]   = 4'(m % 10);
        return r;
    endfunction

    // Shared 4-digit BCD adder/subtractor, mod 10^4.
    always_comb begin
        if (alu_op) begin
            alu_s = bcd(dec(alu_a) - dec(alu_b));
        end else begin
            alu_s = bcd(dec(alu_a) + dec(alu_b));
        end
    end

    // Reference model of one physics step in decimal terms.
    function automatic vec_t model(input logic [15:0] a, v, f, t);
        vec_t r;
        int   sum;
        int   fr;
        r.a = a; r.v = v; r.f = f; r.t = t;
        r.ea = 16'h0000; r.ev = 16'h0000; r.ef = 16'h0000;
        sum = (dec(a) + dec(v)) % 10000;
        if (sum >= 8000 || sum == 0) begin
            r.outcome = (dec(v) >= 9970 || dec(v) == 0) ? 1 : 2;
        end else begin
            r.outcome = 0;
            r.ea = bcd(sum);
            r.ev = bcd(dec(v) - 5 + ((dec(f) == 0) ? 0 : dec(t)));
            fr   = (dec(f) - dec(t) + 10000) % 10000;
            r.ef = (fr >= 8000 || fr == 0) ? 16'h0000 : bcd(fr);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Launch one step and check every cycle up to one past the commit.
    // xk >= 1 raises an extra tick after edge T+xk (sampled at T+xk+1).
    task automatic run_step(input vec_t e, input int xk);
        @(negedge clk);
        alt = e.a; vel = e.v; fuel = e.f; thrust = e.t;
        tick = 1'b1;
        run  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        run    = 1'($urandom_range(0, 1));
        alt    = bcd(int'($urandom_range(0, 9999)));
        vel    = bcd(int'($urandom_range(0, 9999)));
        fuel   = bcd(int'($urandom_range(0, 9999)));
        thrust = bcd(int'($urandom_range(0, 9999)));
        chk("busy_after_tick", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            tick = 1'b0;
            if (e.outcome == 0) begin
                chk($sformatf("wen_k%0d", k), {63'd0, wen}, {63'd0, (k == 4)});
                chk($sformatf("busy_k%0d", k), {63'd0, busy}, {63'd0, (k <= 4)});
                if (k >= 4) begin
                    chk($sformatf("next_state_k%0d", k), {16'd0, alt_n, vel_n, fuel_n},
                        {16'd0, e.ea, e.ev, e.ef});
                    chk("flags_clear", {62'd0, land, crash}, 64'd0);
                end
            end else begin
                chk($sformatf("term_k%0d", k), {61'd0, wen, busy, land, crash},
                    {61'd0, 1'b0, 1'b0, (e.outcome == 1), (e.outcome == 2)});
            end
            if (k == xk) begin
                tick = 1'b1;
                #1;
                chk($sformatf("overrun_k%0d", k), {63'd0, overrun}, {63'd0, (e.outcome == 0)});
            end
        end
        tick = 1'b0;
    endtask

    vec_t tbl[9];
    vec_t rv;
    bit   term;

    initial begin
        // Hand-computed vectors, applied back to back (reset only after a touchdown).
        tbl[0] = '{16'h4500, 16'h0000, 16'h0800, 16'h0005, 0, 16'h4500, 16'h0000, 16'h0795};
        tbl[1] = '{16'h4500, 16'h0000, 16'h0800, 16'h0000, 0, 16'h4500, 16'h9995, 16'h0800};
        tbl[2] = '{16'h4500, 16'h0000, 16'h0003, 16'h0005, 0, 16'h4500, 16'h0000, 16'h0000};
        tbl[3] = '{16'h4500, 16'h0100, 16'h0000, 16'h0009, 0, 16'h4600, 16'h0095, 16'h0000};
        tbl[4] = '{16'h1234, 16'h0021, 16'h0500, 16'h0100, 0, 16'h1255, 16'h0116, 16'h0400};
        tbl[5] = '{16'h5000, 16'h9990, 16'h0010, 16'h0010, 0, 16'h4990, 16'h9995, 16'h0000};
        tbl[6] = '{16'h0003, 16'h9995, 16'h0100, 16'h0001, 1, 16'h0000, 16'h0000, 16'h0000};
        tbl[7] = '{16'h0010, 16'h9950, 16'h0100, 16'h0001, 2, 16'h0000, 16'h0000, 16'h0000};
        tbl[8] = '{16'h0000, 16'h0000, 16'h0100, 16'h0001, 1, 16'h0000, 16'h0000, 16'h0000};

        // Reset state.
        #1;
        chk("reset_outputs", {1'b0, alu_a, alu_b, alu_op, alt_n[15:1], 1'b0},
            {1'b0, 16'h0000, 16'h0000, 1'b0, 15'h0000, 1'b0});
        chk("reset_regs", {3'd0, alt_n, vel_n, fuel_n, wen, busy, land, crash, overrun},
            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_alu_zero", {31'd0, alu_a, alu_b, alu_op}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_step(tbl[i], -1);
            if (tbl[i].outcome != 0) begin
                // Terminal state ignores ticks and never raises overrun.
                @(negedge clk);
                tick = 1'b1;
                run  = 1'b1;
                #1;
                chk("term_no_overrun", {63'd0, overrun}, 64'd0);
                chk("term_alu_zero", {31'd0, alu_a, alu_b, alu_op}, 64'd0);
                @(posedge clk);
                @(negedge clk);
                tick = 1'b0;
                chk("term_hold", {61'd0, wen, busy, land, crash},
                    {61'd0, 1'b0, 1'b0, (tbl[i].outcome == 1), (tbl[i].outcome == 2)});
                do_reset();
            end
        end

        // Ticks while busy are dropped with overrun, including at the commit edge.
        run_step(tbl[0], 1);
        run_step(tbl[4], 2);
        run_step(tbl[1], 4);

        // Reset in the middle of a step discards it.
        @(negedge clk);
        alt = tbl[4].a; vel = tbl[4].v; fuel = tbl[4].f; thrust = tbl[4].t;
        tick = 1'b1;
        run  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tick  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midstep_reset", {3'd0, alt_n, vel_n, fuel_n, wen, busy, land, crash, overrun},
            64'd0);
        chk("midstep_reset_alu", {31'd0, alu_a, alu_b, alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_wen_after_reset", {62'd0, wen, busy}, 64'd0);
        end

        // Randomized steps against the reference model.
        term = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (term) begin
                do_reset();
            end
            if ($urandom_range(0, 1) == 0) begin
                rv = model(bcd(int'($urandom_range(0, 9999))), bcd(int'($urandom_range(0, 150))),
                           bcd(int'($urandom_range(0, 300))), bcd(int'($urandom_range(0, 40))));
            end else begin
                rv = model(bcd(int'($urandom_range(0, 400))), bcd(int'($urandom_range(9800, 9999))),
                           bcd(int'($urandom_range(0, 300))), bcd(int'($urandom_range(0, 40))));
            end
            run_step(rv, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : -1);
            term = (rv.outcome != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
